// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the 32x32 register file write port.
// Buffers requests, drops protected targets, exports pending-write scoreboard.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [4:0]              InAddr,
  input  logic [DATA_W-1:0]       InData,
  output logic                    RegWrite,
  output logic [4:0]              WAddr,
  output logic [DATA_W-1:0]       WData,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    ProtDrop,
  output logic [31:0]             Busy,
  input  logic [4:0]              QAddr1,
  input  logic [4:0]              QAddr2,
  output logic                    FwdHit1,
  output logic                    FwdHit2,
  output logic [DATA_W-1:0]       FwdData1,
  output logic [DATA_W-1:0]       FwdData2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [4:0]        r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic              r_regwrite;
  logic [4:0]        r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_protdrop;

  logic              w_prot;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_idx;
  logic [31:0]       w_busy;
  logic [DATA_W-1:0] w_fd1;
  logic [DATA_W-1:0] w_fd2;

  assign w_prot   = (InAddr == 5'd0) | (InAddr == 5'd26) |
                    (InAddr == 5'd27);
  assign InReady  = r_count < CW'(DEPTH);
  assign w_accept = InValid & InReady;
  assign w_push   = w_accept & ~w_prot;
  assign w_pop    = r_count != '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_regwrite <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_protdrop <= 1'b0;
    end else begin
      r_protdrop <= w_accept & w_prot;
      r_regwrite <= w_pop;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_waddr  <= r_mem_addr[r_rd_ptr];
        r_wdata  <= r_mem_data[r_rd_ptr];
      end
    end
  end

  // Storage needs no reset: validity is defined by r_count alone.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= InAddr;
      r_mem_data[r_wr_ptr] <= InData;
    end
  end

  // Walk oldest to newest so later matches override earlier ones.
  always_comb begin
    w_busy = '0;
    w_fd1  = '0;
    w_fd2  = '0;
    w_idx  = '0;
    if (r_regwrite) begin
      w_busy[r_waddr] = 1'b1;
      if (r_waddr == QAddr1) w_fd1 = r_wdata;
      if (r_waddr == QAddr2) w_fd2 = r_wdata;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if (CW'(k) < r_count) begin
        w_busy[r_mem_addr[w_idx]] = 1'b1;
        if (r_mem_addr[w_idx] == QAddr1) w_fd1 = r_mem_data[w_idx];
        if (r_mem_addr[w_idx] == QAddr2) w_fd2 = r_mem_data[w_idx];
      end
    end
    w_busy[0] = 1'b0;
  end

  assign Busy     = w_busy;
  assign FwdHit1  = w_busy[QAddr1];
  assign FwdHit2  = w_busy[QAddr2];
  assign FwdData1 = FwdHit1 ? w_fd1 : '0;
  assign FwdData2 = FwdHit2 ? w_fd2 : '0;
  assign RegWrite = r_regwrite;
  assign WAddr    = r_waddr;
  assign WData    = r_wdata;
  assign Count    = r_count;
  assign ProtDrop = r_protdrop;

endmodule
